// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB bridge constants, address map and FSM state type
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Three contiguous 64 MB peripheral windows; PSEL_LIMIT is exclusive.
  localparam logic [31:0] PSEL0_BASE = 32'h8000_0000;
  localparam logic [31:0] PSEL1_BASE = 32'h8400_0000;
  localparam logic [31:0] PSEL2_BASE = 32'h8800_0000;
  localparam logic [31:0] PSEL_LIMIT = 32'h8C00_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational transfer qualification and one-hot peripheral select
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [1:0]        Htrans,
  input  logic              Hreadyin,
  output logic              valid,
  output logic [2:0]        tempselx
);

  logic active_trans;

  assign active_trans = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);

  always_comb begin
    tempselx = 3'b000;
    if (Haddr >= ADDR_W'(PSEL0_BASE) && Haddr < ADDR_W'(PSEL1_BASE))
      tempselx = 3'b001;
    else if (Haddr >= ADDR_W'(PSEL1_BASE) && Haddr < ADDR_W'(PSEL2_BASE))
      tempselx = 3'b010;
    else if (Haddr >= ADDR_W'(PSEL2_BASE) && Haddr < ADDR_W'(PSEL_LIMIT))
      tempselx = 3'b100;
  end

  // The windows tile the mapped range exactly, so any select bit means "mapped".
  assign valid = Hreadyin & active_trans & (|tempselx);

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB slave front end with wait states and timeout; AHB_SLV_DECODE_ERR_EN adds unmapped-address ERROR
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              apb_done,
  output logic              valid,
  output logic [2:0]        tempselx,
  output logic [ADDR_W-1:0] Haddr1,
  output logic [ADDR_W-1:0] Haddr2,
  output logic [DATA_W-1:0] Hwdata1,
  output logic [DATA_W-1:0] Hwdata2,
  output logic              Hwritereg,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata
);

  slv_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              hready_q, hready_d;
  logic [1:0]        hresp_q, hresp_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [ADDR_W-1:0] haddr1_q, haddr2_q;
  logic [DATA_W-1:0] hwdata1_q, hwdata2_q;
  logic              hwritereg_q;

  ahb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .Haddr    (Haddr),
    .Htrans   (Htrans),
    .Hreadyin (Hreadyin),
    .valid    (valid),
    .tempselx (tempselx)
  );

`ifdef AHB_SLV_DECODE_ERR_EN
  logic decode_err;
  assign decode_err = Hreadyin & ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ))
                      & (tempselx == 3'b000);
`endif

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      haddr1_q    <= '0;
      haddr2_q    <= '0;
      hwdata1_q   <= '0;
      hwdata2_q   <= '0;
      hwritereg_q <= 1'b0;
    end else begin
      haddr1_q    <= Haddr;
      haddr2_q    <= haddr1_q;
      hwdata1_q   <= Hwdata;
      hwdata2_q   <= hwdata1_q;
      hwritereg_q <= Hwrite;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hready_d = hready_q;
    hresp_d  = hresp_q;
    hrdata_d = hrdata_q;
    unique case (state_q)
      ST_IDLE: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        if (valid) begin
          state_d  = ST_BUSY;
          hready_d = 1'b0;
          cnt_d    = 8'd0;
        end
`ifdef AHB_SLV_DECODE_ERR_EN
        else if (decode_err) begin
          state_d  = ST_ERR1;
          hready_d = 1'b0;
          hresp_d  = HRESP_ERROR;
        end
`endif
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // Completion has priority over a timeout landing on the same edge.
        if (apb_done) begin
          state_d  = ST_IDLE;
          hready_d = 1'b1;
          hresp_d  = HRESP_OKAY;
          if (!hwritereg_q) hrdata_d = Prdata;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d  = ST_ERR1;
          hready_d = 1'b0;
          hresp_d  = HRESP_ERROR;
        end
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
      end
      ST_ERR2: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwritereg_q;
  assign Hreadyout = hready_q;
  assign Hresp     = hresp_q;
  assign Hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - randomized transaction-level bench for ahb_slave_if
module tb_ahb_slave_if;

  localparam int TIMEOUT = 16;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        apb_done;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg;
  logic        Hreadyout;
  logic [1:0]  Hresp;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_rdata;
  logic [31:0] prev_addr;

  ahb_slave_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .apb_done(apb_done), .valid(valid), .tempselx(tempselx),
    .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
    .Hwritereg(Hwritereg), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One address phase plus its whole data phase; n = edge index (1-based after
  // the address edge) carrying apb_done, 0 = never.
  task automatic xfer(input logic [31:0] addr, input logic [1:0] tr, input logic wr,
                      input logic rdy, input logic [31:0] wd, input logic [31:0] rd,
                      input int n);
    logic mapped, exp_valid, is_xfer;
    logic [2:0] exp_sel;
    int exp_low, exp_errs, low, errs, j;
    mapped    = (addr >= 32'h8000_0000) && (addr < 32'h8C00_0000);
    exp_sel   = mapped ? (3'b001 << ((addr - 32'h8000_0000) >> 26)) : 3'b000;
    is_xfer   = rdy && (tr == 2'b10 || tr == 2'b11);
    exp_valid = is_xfer && mapped;
    if (exp_valid) begin
      exp_low  = (n >= 1 && n <= TIMEOUT) ? n : TIMEOUT + 1;
      exp_errs = (n >= 1 && n <= TIMEOUT) ? 0 : 2;
      if (!wr && n >= 1 && n <= TIMEOUT) exp_rdata = rd;
    end else begin
      exp_low  = 0;
      exp_errs = 0;
`ifdef AHB_SLV_DECODE_ERR_EN
      if (is_xfer) begin
        exp_low  = 1;
        exp_errs = 2;
      end
`endif
    end

    Haddr = addr; Htrans = tr; Hwrite = wr; Hreadyin = rdy; apb_done = 1'b0;
    #1;
    check("valid", valid, exp_valid);
    check("tempselx", tempselx, exp_sel);
    @(posedge Hclk); @(negedge Hclk);
    check("haddr1", Haddr1, addr);
    check("haddr2", Haddr2, prev_addr);
    check("hwritereg", Hwritereg, wr);
    Hwdata = wd;

    low = 0; errs = 0; j = 0;
    while (j < 40) begin
      if (Hreadyout === 1'b0) low++;
      if (Hresp === 2'b01) errs++;
      if (Hreadyout === 1'b1 && Hresp === 2'b00) break;
      apb_done = (j + 1 == n);
      Prdata   = (j + 1 == n) ? rd : $urandom;
      @(posedge Hclk); @(negedge Hclk);
      j++;
    end
    apb_done = 1'b0;
    check("xfer_bound", (j < 40), 1'b1);
    check("wait_cycles", low, exp_low);
    check("err_cycles", errs, exp_errs);
    check("hrdata", Hrdata, exp_rdata);

    Htrans = 2'b00;
    repeat (2) begin @(posedge Hclk); @(negedge Hclk); end
    check("hwdata1", Hwdata1, wd);
    check("hwdata2", Hwdata2, wd);
    prev_addr = addr;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [6];
    edges = '{32'h7FFF_FFFF, 32'h83FF_FFFF, 32'h8400_0000, 32'h8BFF_FFFF,
              32'h8C00_0000, 32'h8800_0000};
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
      1:       return edges[$urandom_range(0, 5)];
      2:       return $urandom;
      default: return 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
    endcase
  endfunction

  initial begin
    Hresetn = 1'b0; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
    Haddr = '0; Hwdata = '0; Prdata = '0; apb_done = 1'b0;
    exp_rdata = '0; prev_addr = '0;
    repeat (3) @(negedge Hclk);
    check("rst_hreadyout", Hreadyout, 1'b1);
    check("rst_hresp", Hresp, 2'b00);
    check("rst_hrdata", Hrdata, 32'h0);
    check("rst_haddr1", Haddr1, 32'h0);
    check("rst_hwdata2", Hwdata2, 32'h0);
    Hresetn = 1'b1;
    @(posedge Hclk); @(negedge Hclk);

    xfer(32'h8000_0001, 2'b10, 1'b1, 1'b1, 32'h0000_00A3, 32'h1111_2222, 3);
    xfer(32'h8000_00A2, 2'b10, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 2);
    xfer(32'h8400_0010, 2'b10, 1'b0, 1'b1, 32'h5, 32'hCAFE_0000, 0);
    xfer(32'h8800_0020, 2'b11, 1'b0, 1'b1, 32'h6, 32'h1234_5678, TIMEOUT);
    xfer(32'h8800_0024, 2'b10, 1'b0, 1'b1, 32'h7, 32'h0BAD_F00D, TIMEOUT + 1);
    xfer(32'h8000_0000, 2'b00, 1'b0, 1'b1, 32'h8, 32'hFFFF_0000, 1);
    xfer(32'h9000_0000, 2'b10, 1'b0, 1'b1, 32'h9, 32'hFFFF_0001, 1);
    xfer(32'h8000_0040, 2'b10, 1'b0, 1'b1, 32'hA, 32'h0000_0001, 1);
    xfer(32'h8000_0040, 2'b10, 1'b0, 1'b0, 32'hB, 32'h0000_0002, 1);

    // Reset in the middle of a wait-stated transfer.
    Haddr = 32'h8800_0004; Htrans = 2'b10; Hwrite = 1'b1; Hreadyin = 1'b1;
    @(posedge Hclk); @(negedge Hclk);
    Hwdata = 32'h55;
    repeat (2) begin @(posedge Hclk); @(negedge Hclk); end
    check("busy_hreadyout", Hreadyout, 1'b0);
    #2 Hresetn = 1'b0;
    #1;
    check("mrst_hreadyout", Hreadyout, 1'b1);
    check("mrst_hresp", Hresp, 2'b00);
    check("mrst_haddr1", Haddr1, 32'h0);
    check("mrst_haddr2", Haddr2, 32'h0);
    check("mrst_hwdata1", Hwdata1, 32'h0);
    check("mrst_hwritereg", Hwritereg, 1'b0);
    check("mrst_hrdata", Hrdata, 32'h0);
    exp_rdata = '0;
    @(negedge Hclk);
    Hresetn = 1'b1; Htrans = 2'b00;
    repeat (2) begin @(posedge Hclk); @(negedge Hclk); end
    prev_addr = Haddr;
    xfer(32'h8400_0100, 2'b10, 1'b0, 1'b1, 32'hC, 32'hA5A5_5A5A, 4);

    for (int k = 0; k < 40; k++) begin
      logic [1:0] tr;
      tr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      xfer(rand_addr(), tr, 1'($urandom), ($urandom_range(0, 9) != 0),
           $urandom, $urandom, $urandom_range(0, 20));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-side slave front end of the AHB-to-APB bridge, directly downstream of the AHB master.
- Qualifies AHB transfers and decodes the peripheral select.
- Pipelines address, data and direction for the APB controller, and drives Hreadyout/Hresp/Hrdata back to the master.
- Inserts wait states until the APB side reports completion, with a timeout that produces an AHB ERROR.

Parameters:
- ADDR_W, 32, AHB address width.
- DATA_W, 32, AHB data width.
- TIMEOUT, 16, max BUSY cycles before ERROR response; legal range 2..255.

Ports:
- Hclk  in  1  bridge clock, rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- Hwrite  in  1  transfer direction, 1 = write.
- Hreadyin  in  1  bus ready from master/interconnect.
- Htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Haddr  in  ADDR_W  address phase address.
- Hwdata  in  DATA_W  data phase write data.
- Prdata  in  DATA_W  read data from APB controller, valid when apb_done=1.
- apb_done  in  1  one-cycle pulse: APB transfer finished.
- valid  out  1  combinational qualified transfer.
- tempselx  out  3  combinational one-hot peripheral select.
- Haddr1, Haddr2  out  ADDR_W  address delayed 1 and 2 cycles.
- Hwdata1, Hwdata2  out  DATA_W  write data delayed 1 and 2 cycles.
- Hwritereg  out  1  Hwrite delayed 1 cycle.
- Hreadyout  out  1  registered slave ready.
- Hresp  out  2  registered response: 00 OKAY, 01 ERROR.
- Hrdata  out  DATA_W  registered read data.

Behaviour:
- Reset (async, Hresetn=0):
  - State IDLE; Hreadyout=1; Hresp=00.
  - Hrdata, Haddr1/2, Hwdata1/2, Hwritereg all 0; wait counter 0.
  - Reset mid-BUSY/ERR abandons the transfer immediately.
- Decode:
  - valid = Hreadyin & Htrans[1] & (0x8000_0000 <= Haddr < 0x8C00_0000).
  - tempselx: 0x8000_0000-0x83FF_FFFF -> 001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100; else 000.
- Pipeline: every posedge, Haddr1<=Haddr, Haddr2<=Haddr1, Hwdata1<=Hwdata, Hwdata2<=Hwdata1, Hwritereg<=Hwrite. No enable; runs free.
- FSM:
  - IDLE: Hreadyout=1, Hresp=00. On valid at the edge -> BUSY, Hreadyout<=0, counter<=0. Htrans IDLE/BUSY or no match -> stay in IDLE with zero wait, OKAY.
  - BUSY: counter increments each cycle.
    - apb_done=1 -> IDLE, Hreadyout<=1. If Hwritereg==0, Hrdata<=Prdata; else Hrdata holds.
    - Else if counter==TIMEOUT-1 -> ERR1.
    - apb_done and timeout on the same edge: apb_done wins (OKAY).
  - ERR1: Hreadyout=0, Hresp=01, one cycle -> ERR2.
  - ERR2: Hreadyout=1, Hresp=01, one cycle -> IDLE (Hresp<=00).
- Latency: minimum 2 cycles from address-phase edge to Hreadyout high (apb_done on the first BUSY edge).
- Address changes are ignored outside IDLE; the master holds its address phase while Hreadyout=0.
- Counter width is 8 bits; it never wraps because TIMEOUT <= 255.
- apb_done in IDLE/ERR1/ERR2 is ignored.

Optional Feature:
- AHB_SLV_DECODE_ERR_EN
- Defined: in IDLE, Hreadyin & Htrans[1] with tempselx==000 -> ERR1/ERR2 two-cycle ERROR response; valid stays 0.
- Undefined: unmapped addresses are silently ignored (OKAY, no wait states).

Decomposition:
- Package ahb_apb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants.
  - Peripheral base/limit constants.
  - FSM state typedef (IDLE, BUSY, ERR1, ERR2).
- Sub-module ahb_addr_decode: combinational valid/tempselx generation from Haddr, Htrans, Hreadyin.

Test Plan:
- Single write: Haddr=0x8000_0001, Htrans=10, Hwrite=1, then Hwdata=0xA3 with apb_done 3 cycles later -> valid=1, tempselx=001, Hwdata1=0xA3, Hreadyout low exactly 3 cycles, Hresp=00.
- Single read: Haddr=0x8000_00A2, Hwrite=0, apb_done with Prdata=0xDEAD_BEEF -> Hrdata=0xDEAD_BEEF as Hreadyout rises.
- Timeout: valid to 0x8400_0010, no apb_done -> tempselx=010, Hreadyout low 16+1 cycles, then Hresp=01 for 2 cycles, Hreadyout pattern 0 then 1.
- Collision: apb_done on the 16th BUSY cycle -> OKAY, no ERR states.
- Htrans=00 or Haddr=0x9000_0000 -> valid=0, Hreadyout stays 1; with AHB_SLV_DECODE_ERR_EN the unmapped case gives 2-cycle ERROR.
- Hresetn low in BUSY -> immediate Hreadyout=1, Hresp=00, pipeline regs 0; next valid transfer completes normally.
